// File: rtl/sat_engine_pkg.sv
// Shared definitions for the SAT engine control path: command codes,
// the clause-bank controller state encoding and clause/var word width helpers.
package sat_engine_pkg;

    // Command codes presented on cmd_i
    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_READ = 2'd1;
    localparam logic [1:0] CMD_BCP  = 2'd2;
    localparam logic [1:0] CMD_BKT  = 2'd3;

    // Clause-bank controller states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RD_OUT,
        ST_BCP_APPLY,
        ST_BCP_WAIT,
        ST_BKT,
        ST_DONE
    } ctrl_state_e;

    // A clause stores two bits per variable (positive and negative literal)
    function automatic int clause_w(input int num_vars);
        return num_vars * 2;
    endfunction

    // A var value carries three bits per variable (assigned, value, implied)
    function automatic int var_w(input int num_vars);
        return num_vars * 3;
    endfunction

endpackage

// File: rtl/clause_bank_ctrl_onehot_dec.sv
// Binary slot index to one-hot select. An index beyond N-1 yields all zeros.
module onehot_dec #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [W-1:0] i_idx,
    output logic [N-1:0] o_onehot
);

    // Decode the index into a single set bit
    // NOTE: the output gets a default before the loop so no path can infer a latch.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(i_idx) == k) begin
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clause_bank_ctrl.sv
// Sequencing controller for a clause bank: serial clause load, slot readback,
// BCP iteration to a var-value fixpoint, and single backtrack pulses.
// Optional build macro CLAUSE_BANK_CTRL_STATS_EN adds a saturating 16-bit count
// of apply_impl pulses on stat_impl_total_o; without it that port is tied to 0.
module clause_bank_ctrl
    import sat_engine_pkg::*;
#(
    parameter int NUM_CLAUSES   = 2,
    parameter int NUM_VARS      = 8,
    parameter int WIDTH_C_LEN   = 4,
    parameter int MAX_BCP_ITERS = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid_i,
    input  logic [1:0]                              cmd_i,
    output logic                                    cmd_ready_o,
    input  logic                                    ld_valid_i,
    output logic                                    ld_ready_o,
    input  logic [clause_w(NUM_VARS)-1:0]           ld_clause_i,
    input  logic [WIDTH_C_LEN-1:0]                  ld_len_i,
    output logic                                    rd_valid_o,
    input  logic                                    rd_ready_i,
    output logic [clause_w(NUM_VARS)-1:0]           rd_clause_o,
    output logic [WIDTH_C_LEN-1:0]                  rd_len_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]          rd_idx_o,
    output logic [NUM_CLAUSES-1:0]                  wr_o,
    output logic [NUM_CLAUSES-1:0]                  rd_o,
    output logic [clause_w(NUM_VARS)-1:0]           clause_o,
    output logic [WIDTH_C_LEN-1:0]                  clause_len_o,
    input  logic [clause_w(NUM_VARS)-1:0]           clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0]      clause_len_i,
    input  logic [var_w(NUM_VARS)-1:0]              var_value_i,
    input  logic                                    all_c_sat_i,
    output logic                                    apply_impl_o,
    output logic                                    apply_bkt_o,
    output logic                                    done_o,
    output logic                                    sat_o,
    output logic                                    timeout_o,
    output logic [$clog2(MAX_BCP_ITERS+1)-1:0]      bcp_iters_o,
    output logic [15:0]                             stat_impl_total_o
);

    localparam int CW     = clause_w(NUM_VARS);
    localparam int VW     = var_w(NUM_VARS);
    localparam int SLOT_W = $clog2(NUM_CLAUSES);
    localparam int ITER_W = $clog2(MAX_BCP_ITERS + 1);

    ctrl_state_e              r_state;
    logic [SLOT_W-1:0]        r_slot;
    logic [ITER_W-1:0]        r_iters;
    logic [VW-1:0]            r_prev;
    logic [NUM_CLAUSES-1:0]   r_wr;
    logic [NUM_CLAUSES-1:0]   r_rd;
    logic [CW-1:0]            r_clause;
    logic [WIDTH_C_LEN-1:0]   r_clause_len;
    logic                     r_rd_valid;
    logic [CW-1:0]            r_rd_clause;
    logic [WIDTH_C_LEN-1:0]   r_rd_len;
    logic [SLOT_W-1:0]        r_rd_idx;
    logic                     r_apply_impl;
    logic                     r_apply_bkt;
    logic                     r_done;
    logic                     r_sat;
    logic                     r_timeout;
    logic [ITER_W-1:0]        r_bcp_iters;

    logic                     w_accept;
    logic                     w_slot_last;
    logic                     w_iters_max;
    logic                     w_fixpoint;
    logic [WIDTH_C_LEN-1:0]   w_len_slice;
    logic [SLOT_W-1:0]        w_dec_idx;
    logic [NUM_CLAUSES-1:0]   w_dec_onehot;

    assign w_accept    = cmd_valid_i && (r_state == ST_IDLE);
    assign w_slot_last = (r_slot == SLOT_W'(NUM_CLAUSES - 1));
    assign w_iters_max = (r_iters == ITER_W'(MAX_BCP_ITERS));
    assign w_fixpoint  = (var_value_i == r_prev);
    assign w_len_slice = clause_len_i[int'(r_slot)*WIDTH_C_LEN +: WIDTH_C_LEN];

    // Pick the slot whose select is registered this cycle: slot 0 at accept,
    // the following slot when leaving a readback, otherwise the current slot
    always_comb begin
        w_dec_idx = r_slot;
        if (r_state == ST_IDLE) begin
            w_dec_idx = '0;
        end else if (r_state == ST_RD_OUT) begin
            w_dec_idx = r_slot + SLOT_W'(1);
        end
    end

    onehot_dec #(
        .N (NUM_CLAUSES),
        .W (SLOT_W)
    ) u_slot_dec (
        .i_idx    (w_dec_idx),
        .o_onehot (w_dec_onehot)
    );

    // Control FSM: walks the operation and registers each strobe for the following cycle
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: datapath registers, including the var snapshot, are reset too so
            // an aborted operation leaves no stale strobes or results behind.
            r_state      <= ST_IDLE;
            r_slot       <= '0;
            r_iters      <= '0;
            r_prev       <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_clause     <= '0;
            r_clause_len <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_clause  <= '0;
            r_rd_len     <= '0;
            r_rd_idx     <= '0;
            r_apply_impl <= 1'b0;
            r_apply_bkt  <= 1'b0;
            r_done       <= 1'b0;
            r_sat        <= 1'b0;
            r_timeout    <= 1'b0;
            r_bcp_iters  <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below
            r_wr         <= '0;
            r_rd         <= '0;
            r_apply_impl <= 1'b0;
            r_apply_bkt  <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_slot    <= '0;
                        r_iters   <= '0;
                        r_timeout <= 1'b0;
                        case (cmd_i)
                            CMD_LOAD: r_state <= ST_LOAD;
                            CMD_READ: begin
                                r_state <= ST_RD_REQ;
                                r_rd    <= w_dec_onehot;
                            end
                            CMD_BCP: begin
                                r_state      <= ST_BCP_APPLY;
                                r_apply_impl <= 1'b1;
                            end
                            default: begin
                                r_state     <= ST_BKT;
                                r_apply_bkt <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (ld_valid_i) begin
                        r_clause     <= ld_clause_i;
                        r_clause_len <= ld_len_i;
                        r_wr         <= w_dec_onehot;
                        if (w_slot_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                end

                ST_RD_REQ: r_state <= ST_RD_CAP;

                ST_RD_CAP: begin
                    r_rd_clause <= clause_i;
                    r_rd_len    <= w_len_slice;
                    r_rd_idx    <= r_slot;
                    r_rd_valid  <= 1'b1;
                    r_state     <= ST_RD_OUT;
                end

                ST_RD_OUT: begin
                    if (rd_ready_i) begin
                        r_rd_valid <= 1'b0;
                        if (w_slot_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_slot  <= r_slot + SLOT_W'(1);
                            r_rd    <= w_dec_onehot;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end

                ST_BCP_APPLY: begin
                    r_prev  <= var_value_i;
                    r_iters <= r_iters + ITER_W'(1);
                    r_state <= ST_BCP_WAIT;
                end

                ST_BCP_WAIT: begin
                    if (w_fixpoint) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_iters_max) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                    end else begin
                        r_apply_impl <= 1'b1;
                        r_state      <= ST_BCP_APPLY;
                    end
                end

                ST_BKT: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end

                ST_DONE: begin
                    r_sat       <= all_c_sat_i;
                    r_bcp_iters <= r_iters;
                    r_state     <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (r_state == ST_IDLE);
    assign ld_ready_o   = (r_state == ST_LOAD);
    assign rd_valid_o   = r_rd_valid;
    assign rd_clause_o  = r_rd_clause;
    assign rd_len_o     = r_rd_len;
    assign rd_idx_o     = r_rd_idx;
    assign wr_o         = r_wr;
    assign rd_o         = r_rd;
    assign clause_o     = r_clause;
    assign clause_len_o = r_clause_len;
    assign apply_impl_o = r_apply_impl;
    assign apply_bkt_o  = r_apply_bkt;
    assign done_o       = r_done;
    assign sat_o        = r_sat;
    assign timeout_o    = r_timeout;
    assign bcp_iters_o  = r_bcp_iters;

`ifdef CLAUSE_BANK_CTRL_STATS_EN
    logic [15:0] r_stat_impl_total;

    // Count implication pulses since reset, holding at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_impl_total <= '0;
        end else if (r_apply_impl && (r_stat_impl_total != 16'hFFFF)) begin
            r_stat_impl_total <= r_stat_impl_total + 16'd1;
        end
    end

    assign stat_impl_total_o = r_stat_impl_total;
`else
    assign stat_impl_total_o = 16'h0000;
`endif

endmodule
